// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control stage: default widths, the
// pointer type (address plus wrap bit) and the depth helper.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 7;

  // Address field plus one wrap bit; the wrap bit is what tells full from empty.
  typedef logic [ADDR_WIDTH:0] ptr_t;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer handshake, RAM-side drive and status bundle for fifo_ctrl.
// FIFO_CTRL_ERR_FLAGS_EN adds the sticky overflow/underflow outputs.
interface fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int address_width = ADDR_WIDTH
);

  logic                     wr_en;
  logic [data_width-1:0]    wr_data;
  logic                     rd_en;
  logic                     ram_we;
  logic [address_width-1:0] ram_add_w;
  logic [data_width-1:0]    ram_data_w;
  logic [address_width-1:0] ram_add_r;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic [address_width:0]   count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic                     overflow;
  logic                     underflow;

  modport slave (
    input  wr_en, wr_data, rd_en,
    output ram_we, ram_add_w, ram_data_w, ram_add_r,
    output full, empty, almost_full, count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, rd_en,
    input  ram_we, ram_add_w, ram_data_w, ram_add_r,
    input  full, empty, almost_full, count, overflow, underflow
  );
`else
  modport slave (
    input  wr_en, wr_data, rd_en,
    output ram_we, ram_add_w, ram_data_w, ram_add_r,
    output full, empty, almost_full, count
  );

  modport master (
    output wr_en, wr_data, rd_en,
    input  ram_we, ram_add_w, ram_data_w, ram_add_r,
    input  full, empty, almost_full, count
  );
`endif

endinterface

// File: rtl/fifo_ptr.sv
// Enable-gated binary pointer with a wrap bit in the MSB. The address field
// rolls over DEPTH-1 -> 0 naturally, toggling the MSB on the way.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [addr_width:0] ptr
);

  logic [addr_width:0] ptr_d, ptr_q;

  // Advance by one on an accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + 1'b1;
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage in front of a sync-write / async-read 2-port RAM.
// Owns the pointers, occupancy count and status flags; the RAM's async read
// port gives first-word-fall-through data at ram_add_r.
// Optional build macro: FIFO_CTRL_ERR_FLAGS_EN (sticky overflow/underflow).
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width        = DATA_WIDTH,
  parameter int address_width     = ADDR_WIDTH,
  parameter int almost_full_level = 120
) (
  input  logic      clk,
  input  logic      rst,
  fifo_ctrl_if.slave bus
);

  localparam logic [address_width:0] AF_LEVEL = almost_full_level[address_width:0];

  logic [address_width:0]  wr_ptr, rd_ptr;
  logic [address_width:0]  count_d, count_q;
  logic [data_width-1:0]   wr_word;
  logic                    full, empty;
  logic                    wr_ok, rd_ok;

  // Flags come only from registered pointers, never from the requests.
  assign full  = (wr_ptr[address_width] != rd_ptr[address_width]) &&
                 (wr_ptr[address_width-1:0] == rd_ptr[address_width-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Gating with rst keeps ram_we low for the whole reset, even with wr_en held.
  assign wr_ok = bus.wr_en & ~full & ~rst;
  assign rd_ok = bus.rd_en & ~empty;

  fifo_ptr #(.addr_width(address_width)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_ok),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.addr_width(address_width)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_ok),
    .ptr (rd_ptr)
  );

  // Occupancy moves only when exactly one side transfers.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign wr_word          = bus.wr_data;
  assign bus.ram_data_w   = wr_word;
  assign bus.ram_we       = wr_ok;
  assign bus.ram_add_w    = wr_ptr[address_width-1:0];
  assign bus.ram_add_r    = rd_ptr[address_width-1:0];
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_LEVEL);
  assign bus.count        = count_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_d, overflow_q, underflow_d, underflow_q;

  // Latch any illegal request; only reset clears the record.
  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en & full);
    underflow_d = underflow_q | (bus.rd_en & empty);
  end

  // Sticky error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: the driver predicts each cycle's outputs
// from a queue model and pushes them; a negedge monitor pops and compares.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int AF    = 120;

  typedef struct {
    int          cnt;
    bit          full;
    bit          empty;
    bit          af;
    bit          we;
    int          add_w;
    int          add_r;
    bit          rd_ok;
    logic [7:0]  data;
    bit          ovf;
    bit          udf;
  } rec_t;

  logic clk = 1'b0;
  logic rst;

  fifo_ctrl_if #(.data_width(DATA_WIDTH), .address_width(ADDR_WIDTH)) bus ();

  fifo_ctrl #(
    .data_width        (DATA_WIDTH),
    .address_width     (ADDR_WIDTH),
    .almost_full_level (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // 2-port RAM: synchronous write, asynchronous read
  logic [7:0] mem [DEPTH];
  logic [7:0] data_r;
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_add_w] <= bus.ram_data_w;
  assign data_r = mem[bus.ram_add_r];

  // reference model
  logic [7:0] m_data [$];
  ptr_t       m_wr, m_rd;
  bit         m_ovf, m_udf;
  rec_t       chk_q [$];
  rec_t       mon_rec;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit w, input bit r, input logic [7:0] d);
    rec_t e;
    int   sz;
    @(posedge clk);
    #1;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.wr_data = d;
    sz      = m_data.size();
    e.cnt   = sz;
    e.full  = (sz == DEPTH);
    e.empty = (sz == 0);
    e.af    = (sz >= AF);
    e.we    = w && (sz < DEPTH);
    e.add_w = int'(m_wr[ADDR_WIDTH-1:0]);
    e.add_r = int'(m_rd[ADDR_WIDTH-1:0]);
    e.rd_ok = r && (sz > 0);
    e.data  = e.rd_ok ? m_data[0] : 8'h00;
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    chk_q.push_back(e);
    if (w && sz == DEPTH) m_ovf = 1'b1;
    if (r && sz == 0)     m_udf = 1'b1;
    if (e.rd_ok) begin
      void'(m_data.pop_front());
      m_rd = m_rd + 1'b1;
    end
    if (e.we) begin
      m_data.push_back(d);
      m_wr = m_wr + 1'b1;
    end
  endtask

  // Assert rst between edges with requests active; outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    if (chk_q.size() != 0) begin
      n_err++;
      $display("FAIL monitor_backlog: got %0d pending expected 0", chk_q.size());
      chk_q.delete();
    end
    #1;
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    #1;
    chk("rst_count",  32'(bus.count),      0);
    chk("rst_empty",  32'(bus.empty),      1);
    chk("rst_full",   32'(bus.full),       0);
    chk("rst_af",     32'(bus.almost_full), 0);
    chk("rst_we",     32'(bus.ram_we),     0);
    chk("rst_add_w",  32'(bus.ram_add_w),  0);
    chk("rst_add_r",  32'(bus.ram_add_r),  0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    chk("rst_ovf",    32'(bus.overflow),   0);
    chk("rst_udf",    32'(bus.underflow),  0);
`endif
    m_data.delete();
    m_wr  = '0;
    m_rd  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: compare whatever the driver predicted for this cycle
  always @(negedge clk) begin
    if (chk_q.size() > 0) begin
      mon_rec = chk_q.pop_front();
      chk("count",       32'(bus.count),       32'(mon_rec.cnt));
      chk("full",        32'(bus.full),        32'(mon_rec.full));
      chk("empty",       32'(bus.empty),       32'(mon_rec.empty));
      chk("almost_full", 32'(bus.almost_full), 32'(mon_rec.af));
      chk("ram_we",      32'(bus.ram_we),      32'(mon_rec.we));
      chk("ram_add_w",   32'(bus.ram_add_w),   32'(mon_rec.add_w));
      chk("ram_add_r",   32'(bus.ram_add_r),   32'(mon_rec.add_r));
      if (bus.ram_we) chk("ram_data_w", 32'(bus.ram_data_w), 32'(bus.wr_data));
      if (mon_rec.rd_ok) chk("head_data", 32'(data_r), 32'(mon_rec.data));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow",    32'(bus.overflow),    32'(mon_rec.ovf));
      chk("underflow",   32'(bus.underflow),   32'(mon_rec.udf));
`endif
    end
  end

  initial begin
    int pw, pr;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    m_wr  = '0;
    m_rd  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #12;
    chk("init_count", 32'(bus.count), 0);
    chk("init_empty", 32'(bus.empty), 1);
    chk("init_full",  32'(bus.full),  0);
    chk("init_we",    32'(bus.ram_we), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle, then simultaneous request while empty (write only)
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(1, 1, 8'h11);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'($urandom));
    cyc(0, 0, 8'h00);
    mid_reset();

    // fill with 0x00..0x7F, one refused write, drain in order, one refused read
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(i));
    cyc(1, 0, 8'hAA);
    cyc(0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // simultaneous at full (read only), then steady streaming at 50
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'($urandom));
    cyc(1, 1, 8'h5A);
    for (int i = 0; i < DEPTH - 1 - 50; i++) cyc(0, 1, 8'h00);
    for (int i = 0; i < 10; i++) cyc(1, 1, 8'($urandom));
    for (int i = 0; i < 50; i++) cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    mid_reset();

    // wrap-around: 100 in, 100 out, 60 in across the 127->0 boundary, 60 out
    for (int i = 0; i < 100; i++) cyc(1, 0, 8'($urandom));
    for (int i = 0; i < 100; i++) cyc(0, 1, 8'h00);
    for (int i = 0; i < 60; i++)  cyc(1, 0, 8'(8'h80 + i));
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 60; i++)  cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);

    // randomized traffic with shifting write/read bias
    for (int ph = 0; ph < 4; ph++) begin
      pw = (ph == 0) ? 80 : (ph == 1) ? 50 : (ph == 2) ? 25 : 60;
      pr = (ph == 0) ? 30 : (ph == 1) ? 50 : (ph == 2) ? 80 : 40;
      for (int i = 0; i < 800; i++)
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
    end
    cyc(0, 0, 8'h00);
    mid_reset();
    cyc(0, 0, 8'h00);

    begin
      int k;
      k = 0;
      while (chk_q.size() > 0 && k < 5) begin
        @(negedge clk);
        #1;
        k++;
      end
      if (chk_q.size() > 0) begin
        n_err++;
        $display("FAIL drain_timeout: got %0d pending expected 0", chk_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO control stage that sits directly upstream of the team's 2-port RAM (synchronous write, asynchronous read).
- Owns the write/read pointers and full/empty/count status.
- Drives the RAM write-enable, write address and read address. The RAM's asynchronous read port gives first-word-fall-through output.
- Used wherever a byte stream must be buffered between a producer and a consumer in one clock domain.

Parameters:
- data_width, 8, width of each stored word (must match the RAM instance).
- address_width, 7, RAM address width; depth DEPTH = 2**address_width (128 by default).
- almost_full_level, 120, occupancy at or above which almost_full is asserted; legal range 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  producer write request
- wr_data  in  data_width  producer data
- rd_en  in  1  consumer pop request
- ram_we  out  1  to RAM we
- ram_add_w  out  address_width  to RAM add_w
- ram_data_w  out  data_width  to RAM data_w; combinational copy of wr_data
- ram_add_r  out  address_width  to RAM add_r
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= almost_full_level
- count  out  address_width+1  current occupancy, 0..DEPTH

Behaviour:
- Pointers wr_ptr and rd_ptr are address_width+1 bits wide. The MSB is the wrap bit.
  - ram_add_w = wr_ptr[address_width-1:0]
  - ram_add_r = rd_ptr[address_width-1:0]
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0. Outputs go to empty=1, full=0, almost_full=0, ram_we=0, ram_add_w=0, ram_add_r=0. Outputs hold these values for as long as rst is high.
- Reset mid-operation discards all stored data. RAM contents are not cleared, but they become unreachable.
- Accepted write: wr_ok = wr_en & ~full.
  - ram_we = wr_ok, combinational.
  - The RAM captures the word on the same rising edge that increments wr_ptr.
- Accepted read: rd_ok = rd_en & ~empty.
  - rd_ptr increments on the rising edge.
  - The head word is valid on the RAM data_r whenever empty=0, with zero latency. The consumer samples data_r in the same cycle it asserts rd_en.
- Write-to-read latency: a word written at edge N is visible at the head (empty=0) after edge N, i.e. one cycle.
- count update per edge:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged on both or neither
- Flags:
  - full  = (wr_ptr[MSB] != rd_ptr[MSB]) && (addresses equal)
  - empty = (wr_ptr == rd_ptr)
  - almost_full = (count >= almost_full_level)
  - All flags are derived from registered state, so there is no combinational path from wr_en/rd_en to the flags.
- Boundary cases:
  - Write while full: ignored. ram_we=0, no pointer change.
  - Read while empty: ignored, no pointer change.
  - Simultaneous wr_en and rd_en while empty: write accepted, read rejected; count becomes 1.
  - Simultaneous wr_en and rd_en while full: read accepted, write rejected; count becomes DEPTH-1.
  - Simultaneous wr_en and rd_en otherwise: both accepted; count unchanged.
  - Pointer wrap: the address field wraps from DEPTH-1 to 0 and the MSB toggles.

Optional Feature:
- Macro FIFO_CTRL_ERR_FLAGS_EN adds two outputs, overflow and underflow (1 bit each).
  - overflow sets on any edge where wr_en & full.
  - underflow sets on any edge where rd_en & empty.
  - Both flags are sticky and clear only on rst.
- Without the macro these ports do not exist, and illegal requests are silently ignored as above.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH=8 and ADDR_WIDTH=7
  - a DEPTH function of address width
  - the pointer typedef ptr_t (ADDR_WIDTH+1 bits)
- One natural sub-module: fifo_ptr, an enable-gated binary pointer with wrap bit and async reset. It is instantiated twice, once for writes and once for reads.
- count and the flag logic stay in fifo_ctrl.

Test Plan:
- Reset check: assert rst mid-stream with count=5 -> count=0, empty=1, full=0, ram_we=0 immediately, without waiting for a clk edge.
- Fill test: 128 consecutive writes of 0x00..0x7F -> full=1 after edge 128. almost_full rises after edge 120. A 129th write gives ram_we=0 and count stays 128.
- Drain test: 128 reads following the fill -> head data 0x00..0x7F in order, empty=1 after the last read. A further rd_en leaves rd_ptr unchanged.
- Simultaneous access:
  - wr_en=rd_en=1 with count=0 -> count=1, write only.
  - Same at count=128 -> count=127, read only.
  - Same at count=50 for 10 cycles -> count stays 50 and data order is preserved.
- Wrap-around: write 100 words, read 100, write 60 -> ram_add_w wraps through 127->0 (MSB toggles), count=60, first word read back equals the first of the 60.
- With FIFO_CTRL_ERR_FLAGS_EN: write when full -> overflow=1 and it stays high; read when empty -> underflow=1; both clear on rst.
